// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: opcodes, branch funct3,
// ALU-control op codes, datapath source selects and sequencer state encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  // States that hold mem_req high and wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Memory wait watchdog: counts consecutive unanswered request cycles, flags a timeout
// combinationally in the limit cycle and keeps a sticky bus error until reset.
// Latency: timeout is same-cycle; bus_err registers one cycle later. No backpressure.
module mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  input  logic state_change,
  output logic timeout,
  output logic bus_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // The limit cycle is the one whose increment would reach WAIT_LIMIT; a
  // mem_ready in that same cycle suppresses the timeout.
  assign timeout = waiting && !mem_ready && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state_change || mem_ready || !waiting) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main sequencer for the multicycle RV32 core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Latency with zero-wait memory: R/I 4, load 5, store 4, branch 3 cycles.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready; watchdog halts on timeout.
module multicycle_main_control
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  state_t state, next_state;
  logic   illegal_q, illegal_set;
  logic   waiting, state_change, timeout;
  logic   branch_ok, taken;

  assign branch_ok    = (funct3 == F3_BEQ) || (funct3 == F3_BLT);
  assign taken        = ((funct3 == F3_BEQ) && alu_zero) || ((funct3 == F3_BLT) && alu_lt);
  assign waiting      = is_mem_state(state);
  assign state_change = (next_state != state);

  mem_wait_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .waiting      (waiting),
    .mem_ready    (mem_ready),
    .state_change (state_change),
    .timeout      (timeout),
    .bus_err      (bus_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (illegal_set) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    illegal_set = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    alu_op      = ALU_OP_ADD;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_HALT;
      end
      S_DECODE: begin
        // Branch target (oldPC + imm) is parked in ALUOut here.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R_TYPE:          next_state = S_EXEC_R;
          OP_I_TYPE:          next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          default: begin
            illegal_set = 1'b1;
            next_state  = S_HALT;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)    next_state = S_MEM_WB;
        else if (timeout) next_state = S_HALT;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_HALT;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_OP_BRANCH;
        pc_src    = 1'b1;
        if (branch_ok) begin
          pc_write   = taken;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else begin
          illegal_set = 1'b1;
          next_state  = S_HALT;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase

    // A reset cycle aborts the instruction: no enable may reach the datapath.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal   = illegal_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed vector table, hand-written multi-cycle
// sequences, then random instruction streams checked against a plan-queue model.
import rv_ctrl_pkg::*;

module tb_multicycle_main_control;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0;
  logic       alu_lt = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal, bus_err;
  logic [3:0] state_dbg;

  multicycle_main_control #(.WAIT_LIMIT(WL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic [1:0] src_a, src_b, alu_op;
    logic       reg_write, mem_to_reg, instr_done, illegal, bus_err;
  } outs_t;

  // Flag order: mem_req mem_we ir_write pc_write pc_src alu_op[1:0] reg_write instr_done illegal
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, lt, rdy;
    state_t     st;
    logic [9:0] fl;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [7:0] LW_RDY  = 8'b11000111;
  localparam logic [7:0] LW_REQ  = 8'b01111001;
  localparam logic [7:0] LW_DONE = 8'b10000000;
  state_t lw_st [8] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};

  // Reference model: an instruction is a queue of remaining phases.
  state_t mph;
  state_t plan[$];
  int     mw;
  bit     mill, mbus;
  int     halt_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic add_row(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input logic lt, input logic rdy, input state_t st, input logic [9:0] fl);
    vec_t v;
    v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.rdy = rdy; v.st = st; v.fl = fl;
    tbl.push_back(v);
  endtask

  function automatic outs_t act_outs();
    return {state_dbg, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
            alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal, bus_err};
  endfunction

  function automatic logic [13:0] act_sub();
    return {state_dbg, mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
            reg_write, instr_done, illegal};
  endfunction

  function automatic outs_t expect_outs(input state_t p);
    outs_t o;
    logic  br_ok, tk;
    br_ok = (funct3 == 3'b000) || (funct3 == 3'b100);
    tk    = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b100) && alu_lt);
    o = '0;
    o.st = p; o.illegal = mill; o.bus_err = mbus;
    case (p)
      S_FETCH:    begin o.mem_req = 1; o.src_b = 2'b01; o.ir_write = mem_ready; o.pc_write = mem_ready; end
      S_DECODE:   begin o.src_a = 2'b10; o.src_b = 2'b10; end
      S_EXEC_R:   begin o.src_a = 2'b01; o.alu_op = 2'b10; end
      S_EXEC_I:   begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 2'b10; end
      S_ALU_WB:   begin o.reg_write = 1; o.instr_done = 1; end
      S_MEM_ADDR: begin o.src_a = 2'b01; o.src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_req = 1; o.i_or_d = 1; end
      S_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      S_MEM_WR:   begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; o.instr_done = mem_ready; end
      S_BRANCH:   begin o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_src = 1;
                        o.pc_write = br_ok && tk; o.instr_done = br_ok; end
      default:    ;
    endcase
    return o;
  endfunction

  task automatic next_phase();
    mw = 0;
    if (plan.size() > 0) mph = plan.pop_front();
    else begin
      mph = S_FETCH;
      plan.push_back(S_DECODE);
    end
  endtask

  task automatic model_reset();
    mph = S_FETCH; plan.delete(); plan.push_back(S_DECODE);
    mw = 0; mill = 0; mbus = 0;
  endtask

  task automatic model_step();
    case (mph)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) next_phase();
        else begin
          mw++;
          if (mw >= WL) begin mbus = 1; mph = S_HALT; end
        end
      end
      S_DECODE: begin
        plan.delete();
        case (opcode)
          OP_R_TYPE: begin plan.push_back(S_EXEC_R); plan.push_back(S_ALU_WB); end
          OP_I_TYPE: begin plan.push_back(S_EXEC_I); plan.push_back(S_ALU_WB); end
          OP_LOAD:   begin plan.push_back(S_MEM_ADDR); plan.push_back(S_MEM_RD); plan.push_back(S_MEM_WB); end
          OP_STORE:  begin plan.push_back(S_MEM_ADDR); plan.push_back(S_MEM_WR); end
          OP_BRANCH: plan.push_back(S_BRANCH);
          default:   mill = 1;
        endcase
        if (mill && plan.size() == 0) mph = S_HALT;
        else next_phase();
      end
      S_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b100) next_phase();
        else begin mill = 1; mph = S_HALT; end
      end
      S_HALT: ;
      default: next_phase();
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // add, beq taken/not, blt taken/not, zero-wait store, illegal opcode
    add_row(OP_R_TYPE, 3'd0, 0, 0, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_R_TYPE, 3'd0, 0, 0, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_R_TYPE, 3'd0, 0, 0, 1, S_EXEC_R,   10'b00000_10_000);
    add_row(OP_R_TYPE, 3'd0, 0, 0, 1, S_ALU_WB,   10'b00000_00_110);
    add_row(OP_BRANCH, 3'd0, 1, 0, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_BRANCH, 3'd0, 1, 0, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_BRANCH, 3'd0, 1, 0, 1, S_BRANCH,   10'b00011_01_010);
    add_row(OP_BRANCH, 3'd0, 0, 1, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_BRANCH, 3'd0, 0, 1, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_BRANCH, 3'd0, 0, 1, 1, S_BRANCH,   10'b00001_01_010);
    add_row(OP_BRANCH, 3'd4, 0, 1, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_BRANCH, 3'd4, 0, 1, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_BRANCH, 3'd4, 0, 1, 1, S_BRANCH,   10'b00011_01_010);
    add_row(OP_BRANCH, 3'd4, 1, 0, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_BRANCH, 3'd4, 1, 0, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_BRANCH, 3'd4, 1, 0, 1, S_BRANCH,   10'b00001_01_010);
    add_row(OP_STORE,  3'd2, 0, 0, 1, S_FETCH,    10'b10110_00_000);
    add_row(OP_STORE,  3'd2, 0, 0, 1, S_DECODE,   10'b00000_00_000);
    add_row(OP_STORE,  3'd2, 0, 0, 1, S_MEM_ADDR, 10'b00000_00_000);
    add_row(OP_STORE,  3'd2, 0, 0, 1, S_MEM_WR,   10'b11000_00_010);
    add_row(7'h7f,     3'd0, 0, 0, 1, S_FETCH,    10'b10110_00_000);
    add_row(7'h7f,     3'd0, 0, 0, 1, S_DECODE,   10'b00000_00_000);
    add_row(7'h7f,     3'd0, 0, 0, 1, S_HALT,     10'b00000_00_001);
    add_row(7'h7f,     3'd0, 0, 0, 1, S_HALT,     10'b00000_00_001);

    do_reset();
    @(negedge clk);
    chk("reset_state", {state_dbg, illegal, bus_err, reg_write, instr_done}, {S_FETCH, 4'b0000});
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op; funct3 = tbl[i].f3; alu_zero = tbl[i].z;
      alu_lt = tbl[i].lt; mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl_row%0d", i), act_sub(), {tbl[i].st, tbl[i].fl});
      tick();
    end

    // Reset out of HALT clears illegal; no enables during the reset cycle.
    reset = 1'b1;
    @(negedge clk);
    chk("halt_rst_en", {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}, 0);
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("illegal_clr", {state_dbg, illegal}, {S_FETCH, 1'b0});
    tick();

    // Load with three wait cycles in MEM_RD.
    do_reset();
    opcode = OP_LOAD; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      mem_ready = LW_RDY[i];
      @(negedge clk);
      chk($sformatf("lw_cyc%0d", i + 1), {state_dbg, mem_req, instr_done},
          {lw_st[i], LW_REQ[i], LW_DONE[i]});
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("lw_back_fetch", state_dbg, S_FETCH);
    tick();

    // Watchdog: four unanswered FETCH cycles -> HALT with bus_err.
    do_reset();
    opcode = OP_R_TYPE; mem_ready = 1'b0;
    for (int i = 0; i < WL; i++) begin
      @(negedge clk);
      chk($sformatf("wd_wait%0d", i), {state_dbg, mem_req, bus_err}, {S_FETCH, 1'b1, 1'b0});
      tick();
    end
    @(negedge clk);
    chk("wd_halt", {state_dbg, mem_req, bus_err}, {S_HALT, 1'b0, 1'b1});
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wd_sticky", {state_dbg, ir_write, bus_err}, {S_HALT, 1'b0, 1'b1});
    tick();

    // Ready arriving in the limit cycle completes normally.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < WL - 1; i++) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wd_last_ready", {state_dbg, ir_write, pc_write, bus_err}, {S_FETCH, 1'b1, 1'b1, 1'b0});
    tick();
    @(negedge clk);
    chk("wd_decode", {state_dbg, bus_err}, {S_DECODE, 1'b0});
    tick();

    // Reset during MEM_WR aborts the store.
    do_reset();
    opcode = OP_STORE; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_in_wr", {state_dbg, mem_req, mem_we, i_or_d}, {S_MEM_WR, 3'b111});
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_rst_cycle", {mem_req, mem_we, instr_done}, 3'b000);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("sw_after_rst", {state_dbg, mem_we, instr_done}, {S_FETCH, 2'b00});
    tick();

    // Random instruction streams against the plan-queue model.
    do_reset();
    model_reset();
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (mph == S_HALT && halt_cycles >= 2) begin
        do_reset();
        model_reset();
        halt_cycles = 0;
      end else begin
        if (mph == S_FETCH) begin
          case ($urandom_range(0, 10))
            0, 1:    opcode = OP_R_TYPE;
            2, 3:    opcode = OP_I_TYPE;
            4, 5:    opcode = OP_LOAD;
            6, 7:    opcode = OP_STORE;
            8, 9:    opcode = OP_BRANCH;
            default: opcode = 7'($urandom_range(0, 127));
          endcase
          if ($urandom_range(0, 7) < 6) funct3 = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000;
          else funct3 = 3'($urandom_range(0, 7));
        end
        alu_zero  = 1'($urandom_range(0, 1));
        alu_lt    = 1'($urandom_range(0, 1));
        mem_ready = ($urandom_range(0, 9) < 6);
        @(negedge clk);
        chk("rand", act_outs(), expect_outs(mph));
        model_step();
        if (mph == S_HALT) halt_cycles++;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
